// File: rtl/uart_rx_if.sv
// Byte-delivery handshake between the UART receiver and its consumer.
// The receiver drives data/valid; the consumer drives ready.
interface uart_rx_if;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       rx_ready_i;

    modport master (
        output rx_data_o,
        output rx_valid_o,
        input  rx_ready_i
    );

    modport slave (
        input  rx_data_o,
        input  rx_valid_o,
        output rx_ready_i
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with synchronizer, mid-bit sampling, a one-entry holding
// register on a valid/ready handshake, and framing-error/overrun pulses.
module uart_rx #(
    parameter int CLKS_PER_BIT = 104,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd_i,
    uart_rx_if.master  rx_if,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic       busy_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   rxd_s;
    state_t                 state_r, state_s;
    logic [CNT_W-1:0]       baud_r, baud_s;
    logic [2:0]             bit_r, bit_s;
    logic [7:0]             shift_r, shift_s;
    logic                   good_s, ferr_s;
    logic [7:0]             data_r, data_s;
    logic                   valid_r, valid_s;
    logic                   ovr_s;
    logic                   frame_err_r, overrun_r, busy_r;

    assign rxd_s = sync_r[SYNC_STAGES-1];

    // Metastability synchronizer for the asynchronous serial line
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_r <= '1;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], rxd_i};
        end
    end

    // Frame FSM next-state: start-bit qualify, 8 data samples, stop check, break hold
    always_comb begin
        state_s = state_r;
        baud_s  = baud_r + CNT_W'(1);
        bit_s   = bit_r;
        shift_s = shift_r;
        good_s  = 1'b0;
        ferr_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                baud_s = '0;
                if (!rxd_s) begin
                    state_s = ST_START;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (baud_r == HALF_CNT) begin
                    baud_s = '0;
                    bit_s  = 3'd0;
                    if (!rxd_s) begin
                        state_s = ST_DATA;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    state_s = ST_START;
                end
            end
            ST_DATA: begin
                if (baud_r == LAST_CNT) begin
                    baud_s  = '0;
                    shift_s = {rxd_s, shift_r[7:1]};
                    if (bit_r == 3'd7) begin
                        state_s = ST_STOP;
                        bit_s   = 3'd0;
                    end else begin
                        bit_s = bit_r + 3'd1;
                    end
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_STOP: begin
                if (baud_r == LAST_CNT) begin
                    baud_s = '0;
                    if (rxd_s) begin
                        good_s  = 1'b1;
                        state_s = ST_IDLE;
                    end else begin
                        ferr_s  = 1'b1;
                        state_s = ST_BREAK;
                    end
                end else begin
                    state_s = ST_STOP;
                end
            end
            ST_BREAK: begin
                // A line held low must return high before another start is seen
                baud_s = '0;
                if (rxd_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_BREAK;
                end
            end
            default: begin
                state_s = ST_IDLE;
                baud_s  = '0;
            end
        endcase
    end

    // Holding register: load when empty or being drained, otherwise flag overrun
    always_comb begin
        data_s  = data_r;
        valid_s = valid_r;
        ovr_s   = 1'b0;
        if (good_s) begin
            if (!valid_r || rx_if.rx_ready_i) begin
                data_s  = shift_r;
                valid_s = 1'b1;
            end else begin
                ovr_s = 1'b1;
            end
        end else if (valid_r && rx_if.rx_ready_i) begin
            valid_s = 1'b0;
        end else begin
            valid_s = valid_r;
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            baud_r      <= '0;
            bit_r       <= 3'd0;
            shift_r     <= 8'h00;
            data_r      <= 8'h00;
            valid_r     <= 1'b0;
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            baud_r      <= baud_s;
            bit_r       <= bit_s;
            shift_r     <= shift_s;
            data_r      <= data_s;
            valid_r     <= valid_s;
            frame_err_r <= ferr_s;
            overrun_r   <= ovr_s;
            busy_r      <= (state_s != ST_IDLE);
        end
    end

    assign rx_if.rx_data_o  = data_r;
    assign rx_if.rx_valid_o = valid_r;
    assign frame_err_o      = frame_err_r;
    assign overrun_o        = overrun_r;
    assign busy_o           = busy_r;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: bit-banged 8N1 frames at 4 clocks per bit,
// expectations derived from the bytes sent and the holding-register rules.
module tb_uart_rx;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rxd_i = 1'b1;
    logic frame_err_o, overrun_o, busy_o;

    int total = 0;
    int bad = 0;

    logic [7:0] rx_q[$];
    int valid_cycles = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int viol = 0;
    logic fe_prev = 1'b0;
    logic ov_prev = 1'b0;

    uart_rx_if rx_if ();

    uart_rx #(
        .CLKS_PER_BIT(4),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rxd_i      (rxd_i),
        .rx_if      (rx_if),
        .frame_err_o(frame_err_o),
        .overrun_o  (overrun_o),
        .busy_o     (busy_o)
    );

    always #5 clk = ~clk;

    // Observe handshakes and error pulses away from the active edge
    always @(negedge clk) begin
        if (reset) begin
            fe_prev <= 1'b0;
            ov_prev <= 1'b0;
        end else begin
            if (rx_if.rx_valid_o && rx_if.rx_ready_i) rx_q.push_back(rx_if.rx_data_o);
            if (rx_if.rx_valid_o) valid_cycles <= valid_cycles + 1;
            if (frame_err_o) fe_cnt <= fe_cnt + 1;
            if (overrun_o) ov_cnt <= ov_cnt + 1;
            if ((frame_err_o && fe_prev) || (overrun_o && ov_prev)) viol <= viol + 1;
            fe_prev <= frame_err_o;
            ov_prev <= overrun_o;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic v);
        rxd_i = v;
        cyc(4);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
        rxd_i = 1'b1;
    endtask

    task automatic accept();
        rx_if.rx_ready_i = 1'b1;
        cyc(1);
        rx_if.rx_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rxd_i = 1'b1;
        rx_if.rx_ready_i = 1'b0;
        cyc(3);
        total++;
        if ({rx_if.rx_data_o, rx_if.rx_valid_o, frame_err_o, overrun_o, busy_o} !== 12'h000) begin
            bad++;
            $display("FAIL reset_held: data=%h valid=%b fe=%b ov=%b busy=%b want all 0",
                     rx_if.rx_data_o, rx_if.rx_valid_o, frame_err_o, overrun_o, busy_o);
        end
        reset = 1'b0;
        cyc(20);
        total++;
        if ({rx_if.rx_data_o, rx_if.rx_valid_o, frame_err_o, overrun_o, busy_o} !== 12'h000) begin
            bad++;
            $display("FAIL reset_idle: data=%h valid=%b fe=%b ov=%b busy=%b want all 0",
                     rx_if.rx_data_o, rx_if.rx_valid_o, frame_err_o, overrun_o, busy_o);
        end
    endtask

    task automatic test_single();
        rx_q.delete();
        rx_if.rx_ready_i = 1'b0;
        send_frame(8'hA5, 1'b1);
        total++;
        if (busy_o !== 1'b1 || rx_if.rx_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL single_in_stop: busy=%b valid=%b want busy=1 valid=0", busy_o, rx_if.rx_valid_o);
        end
        cyc(2);
        total++;
        if (rx_if.rx_valid_o !== 1'b1 || rx_if.rx_data_o !== 8'hA5 || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL single_rx: valid=%b data=%h busy=%b want 1 a5 0",
                     rx_if.rx_valid_o, rx_if.rx_data_o, busy_o);
        end
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            total++;
            if ({rx_if.rx_valid_o, rx_if.rx_data_o} !== {1'b1, 8'hA5}) begin
                bad++;
                $display("FAIL single_hold[%0d]: valid=%b data=%h want 1 a5", i, rx_if.rx_valid_o, rx_if.rx_data_o);
            end
        end
        accept();
        total++;
        if (rx_if.rx_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL single_accept: valid=%b want 0", rx_if.rx_valid_o);
        end
        total++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) begin
            bad++;
            $display("FAIL single_handshake: accepted %0d bytes want 1 byte a5", rx_q.size());
        end
    endtask

    task automatic test_glitch();
        int fe0;
        int vc0;
        fe0 = fe_cnt;
        vc0 = valid_cycles;
        rxd_i = 1'b0;
        cyc(1);
        rxd_i = 1'b1;
        cyc(2);
        total++;
        if (busy_o !== 1'b1) begin
            bad++;
            $display("FAIL glitch_seen: busy=%b want 1", busy_o);
        end
        cyc(10);
        total++;
        if (busy_o !== 1'b0 || valid_cycles != vc0 || fe_cnt != fe0) begin
            bad++;
            $display("FAIL glitch_reject: busy=%b valid_cycles=+%0d fe=+%0d want 0 +0 +0",
                     busy_o, valid_cycles - vc0, fe_cnt - fe0);
        end
    endtask

    task automatic test_frame_err();
        int fe0;
        int vc0;
        fe0 = fe_cnt;
        vc0 = valid_cycles;
        rx_if.rx_ready_i = 1'b0;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(1'(8'h3C >> i));
        send_bit(1'b0);
        cyc(12);
        total++;
        if (busy_o !== 1'b1 || fe_cnt != fe0 + 1 || valid_cycles != vc0) begin
            bad++;
            $display("FAIL ferr_break: busy=%b fe=+%0d valid_cycles=+%0d want 1 +1 +0",
                     busy_o, fe_cnt - fe0, valid_cycles - vc0);
        end
        rxd_i = 1'b1;
        cyc(5);
        total++;
        if (busy_o !== 1'b0 || fe_cnt != fe0 + 1 || rx_if.rx_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL ferr_release: busy=%b fe=+%0d valid=%b want 0 +1 0",
                     busy_o, fe_cnt - fe0, rx_if.rx_valid_o);
        end
        send_frame(8'h11, 1'b1);
        cyc(2);
        total++;
        if (rx_if.rx_valid_o !== 1'b1 || rx_if.rx_data_o !== 8'h11) begin
            bad++;
            $display("FAIL ferr_recover: valid=%b data=%h want 1 11", rx_if.rx_valid_o, rx_if.rx_data_o);
        end
        accept();
    endtask

    task automatic test_overrun();
        int ov0;
        ov0 = ov_cnt;
        rx_if.rx_ready_i = 1'b0;
        send_frame(8'h01, 1'b1);
        send_frame(8'h02, 1'b1);
        cyc(2);
        total++;
        if (rx_if.rx_valid_o !== 1'b1 || rx_if.rx_data_o !== 8'h01 || ov_cnt != ov0 + 1) begin
            bad++;
            $display("FAIL overrun: valid=%b data=%h ov=+%0d want 1 01 +1",
                     rx_if.rx_valid_o, rx_if.rx_data_o, ov_cnt - ov0);
        end
        accept();
        total++;
        if (rx_if.rx_valid_o !== 1'b0 || ov_cnt != ov0 + 1) begin
            bad++;
            $display("FAIL overrun_drain: valid=%b ov=+%0d want 0 +1", rx_if.rx_valid_o, ov_cnt - ov0);
        end
    endtask

    task automatic test_back_to_back();
        int ov0;
        int vc0;
        ov0 = ov_cnt;
        vc0 = valid_cycles;
        rx_q.delete();
        rx_if.rx_ready_i = 1'b1;
        send_frame(8'h55, 1'b1);
        send_frame(8'hAA, 1'b1);
        cyc(3);
        rx_if.rx_ready_i = 1'b0;
        total++;
        if (rx_q.size() != 2 || rx_q[0] !== 8'h55 || rx_q[1] !== 8'hAA) begin
            bad++;
            $display("FAIL b2b_data: got %0d bytes want 55,aa", rx_q.size());
        end
        total++;
        if (valid_cycles != vc0 + 2 || ov_cnt != ov0 || rx_if.rx_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL b2b_timing: valid_cycles=+%0d ov=+%0d valid=%b want +2 +0 0",
                     valid_cycles - vc0, ov_cnt - ov0, rx_if.rx_valid_o);
        end
    endtask

    task automatic test_reset_mid();
        int fe0;
        rx_if.rx_ready_i = 1'b0;
        send_frame(8'hC3, 1'b1);
        cyc(2);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        cyc(2);
        reset = 1'b1;
        cyc(1);
        total++;
        if ({rx_if.rx_data_o, rx_if.rx_valid_o, frame_err_o, overrun_o, busy_o} !== 12'h000) begin
            bad++;
            $display("FAIL reset_mid: data=%h valid=%b fe=%b ov=%b busy=%b want all 0",
                     rx_if.rx_data_o, rx_if.rx_valid_o, frame_err_o, overrun_o, busy_o);
        end
        reset = 1'b0;
        fe0 = fe_cnt;
        cyc(20);
        total++;
        if (rx_if.rx_valid_o !== 1'b0 || busy_o !== 1'b0 || fe_cnt != fe0) begin
            bad++;
            $display("FAIL reset_mid_quiet: valid=%b busy=%b fe=+%0d want 0 0 +0",
                     rx_if.rx_valid_o, busy_o, fe_cnt - fe0);
        end
        send_frame(8'h7E, 1'b1);
        cyc(2);
        total++;
        if (rx_if.rx_valid_o !== 1'b1 || rx_if.rx_data_o !== 8'h7E) begin
            bad++;
            $display("FAIL reset_mid_recover: valid=%b data=%h want 1 7e", rx_if.rx_valid_o, rx_if.rx_data_o);
        end
        accept();
    endtask

    task automatic test_random_stream();
        logic [7:0] exp_q[$];
        logic [7:0] b;
        int ov0;
        int fe0;
        ov0 = ov_cnt;
        fe0 = fe_cnt;
        rx_q.delete();
        rx_if.rx_ready_i = 1'b1;
        for (int i = 0; i < 12; i++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            send_frame(b, 1'b1);
            cyc($urandom_range(0, 6));
        end
        cyc(3);
        rx_if.rx_ready_i = 1'b0;
        total++;
        if (rx_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL rand_count: got %0d bytes want %0d", rx_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                total++;
                if (rx_q[i] !== exp_q[i]) begin
                    bad++;
                    $display("FAIL rand_byte[%0d]: got %h want %h", i, rx_q[i], exp_q[i]);
                end
            end
        end
        total++;
        if (ov_cnt != ov0 || fe_cnt != fe0) begin
            bad++;
            $display("FAIL rand_errs: ov=+%0d fe=+%0d want +0 +0", ov_cnt - ov0, fe_cnt - fe0);
        end
    endtask

    task automatic test_random_overrun();
        logic [7:0] first;
        logic [7:0] b;
        int n;
        int ov0;
        rx_if.rx_ready_i = 1'b0;
        for (int it = 0; it < 4; it++) begin
            n = $urandom_range(1, 3);
            ov0 = ov_cnt;
            first = 8'h00;
            for (int k = 0; k < n; k++) begin
                b = 8'($urandom);
                if (k == 0) first = b;
                send_frame(b, 1'b1);
            end
            cyc(2);
            total++;
            if (rx_if.rx_valid_o !== 1'b1 || rx_if.rx_data_o !== first || ov_cnt != ov0 + n - 1) begin
                bad++;
                $display("FAIL rand_ovr[%0d]: valid=%b data=%h ov=+%0d want 1 %h +%0d",
                         it, rx_if.rx_valid_o, rx_if.rx_data_o, ov_cnt - ov0, first, n - 1);
            end
            accept();
        end
    endtask

    task automatic test_pulse_width();
        total++;
        if (viol != 0) begin
            bad++;
            $display("FAIL pulse_width: %0d multi-cycle error pulses want 0", viol);
        end
    endtask

    initial begin
        rx_if.rx_ready_i = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        test_random_stream();
        test_random_overrun();
        test_pulse_width();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
